// File: rtl/johnson_phase_monitor_pkg.sv
// Shared types and defaults for the Johnson counter phase monitor.
// Holds the lock FSM state encoding and the default counter geometry.
package johnson_phase_monitor_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_REV_W    = 8;
    localparam int unsigned ERR_W        = 8;
    localparam int unsigned GOOD_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality, phase index, one-hot phase
// and the canonical successor code.
module johnson_decode #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]              code,
    output logic                          legal,
    output logic [$clog2(2*WIDTH)-1:0]    idx,
    output logic [2*WIDTH-1:0]            onehot,
    output logic [WIDTH-1:0]              next_code
);

    localparam int unsigned NPH = 2 * WIDTH;
    localparam int unsigned IW  = $clog2(NPH);

    logic [IW-1:0]    pop;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;

    // Legal codes are thermometers: LSB-filled when MSB=0, MSB-filled when MSB=1.
    always_comb begin
        pop     = '0;
        lo_mask = '0;
        hi_mask = '0;
        legal   = 1'b0;
        idx     = '0;
        onehot  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + IW'(code[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            lo_mask[i]           = (IW'(i) < pop);
            hi_mask[WIDTH-1-i]   = (IW'(i) < pop);
        end
        if (!code[WIDTH-1]) begin
            legal = (code == lo_mask);
            idx   = pop;
        end else begin
            legal = (code == hi_mask);
            idx   = IW'(NPH) - pop;
        end
        if (legal) begin
            onehot = NPH'(1) << idx;
        end
    end

    assign next_code = {code[WIDTH-2:0], ~code[WIDTH-1]};

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a Johnson counter each clock, decodes its phase and tracks lock,
// revolutions and sequence errors so downstream logic can qualify on locked.
module johnson_phase_monitor
    import johnson_phase_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned REV_W    = DEF_REV_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              count_in,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic                          code_valid,
    output logic                          locked,
    output logic                          seq_err,
    output logic                          fault,
    output logic                          rev_pulse,
    output logic [REV_W-1:0]              rev_count,
    output logic [ERR_W-1:0]              err_count
);

    localparam int unsigned NPH = 2 * WIDTH;
    localparam int unsigned IW  = $clog2(NPH);

    state_t             state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WIDTH-1:0]   last_q;
    logic               seq_err_d;
    logic               rev_pulse_d;
    logic [REV_W-1:0]   rev_count_d;
    logic [ERR_W-1:0]   err_count_d;

    logic               in_legal, last_legal;
    logic [IW-1:0]      in_idx, last_idx;
    logic [NPH-1:0]     in_onehot, last_onehot;
    logic [WIDTH-1:0]   in_next, last_next;
    logic               succ;
    logic               unused_last;

    johnson_decode #(.WIDTH(WIDTH)) u_dec_in (
        .code      (count_in),
        .legal     (in_legal),
        .idx       (in_idx),
        .onehot    (in_onehot),
        .next_code (in_next)
    );

    johnson_decode #(.WIDTH(WIDTH)) u_dec_last (
        .code      (last_q),
        .legal     (last_legal),
        .idx       (last_idx),
        .onehot    (last_onehot),
        .next_code (last_next)
    );

    assign unused_last = ^{last_idx, last_onehot, in_next};

    // A stall or skipped phase never matches the successor of last_q.
    assign succ = in_legal && last_legal && (count_in == last_next);

    // Lock FSM next state and event generation.
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        seq_err_d   = 1'b0;
        rev_pulse_d = 1'b0;
        rev_count_d = rev_count;
        err_count_d = err_count;
        case (state_q)
            IDLE: begin
                if (in_legal) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (!in_legal) begin
                    state_d = IDLE;
                end else if (!succ) begin
                    good_d = '0;
                end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                    state_d = LOCK;
                    good_d  = GOOD_W'(LOCK_CNT);
                end else begin
                    good_d = good_q + GOOD_W'(1);
                end
            end
            LOCK: begin
                if (!succ) begin
                    state_d   = FAULT;
                    seq_err_d = 1'b1;
                end else if (in_idx == '0) begin
                    rev_pulse_d = 1'b1;
                end
            end
            FAULT: begin
                state_d = in_legal ? ACQ : IDLE;
                good_d  = '0;
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
        if (rev_pulse_d) begin
            rev_count_d = rev_count + REV_W'(1);
        end
        if (seq_err_d && (err_count != '1)) begin
            err_count_d = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            good_q       <= '0;
            last_q       <= '0;
            phase_idx    <= '0;
            phase_onehot <= '0;
            code_valid   <= 1'b0;
            locked       <= 1'b0;
            seq_err      <= 1'b0;
            fault        <= 1'b0;
            rev_pulse    <= 1'b0;
            rev_count    <= '0;
            err_count    <= '0;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            last_q       <= count_in;
            phase_idx    <= in_legal ? in_idx : phase_idx;
            phase_onehot <= in_onehot;
            code_valid   <= in_legal;
            locked       <= (state_d == LOCK);
            seq_err      <= seq_err_d;
            fault        <= (state_d == FAULT);
            rev_pulse    <= rev_pulse_d;
            rev_count    <= rev_count_d;
            err_count    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: directed scenarios plus
// random stimulus, checked every cycle against a table-driven model.
module tb_johnson_phase_monitor;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned REV_W    = 8;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_LOCK  = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       count_in;
    logic [2:0]       phase_idx;
    logic [7:0]       phase_onehot;
    logic             code_valid;
    logic             locked;
    logic             seq_err;
    logic             fault;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_count;
    logic [7:0]       err_count;

    johnson_phase_monitor #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT),
        .REV_W    (REV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count_in     (count_in),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .code_valid   (code_valid),
        .locked       (locked),
        .seq_err      (seq_err),
        .fault        (fault),
        .rev_pulse    (rev_pulse),
        .rev_count    (rev_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Canonical phase table; position in the table is the phase index.
    function automatic logic [3:0] canon(input int k);
        case (k % 8)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0011;
            3: return 4'b0111;
            4: return 4'b1111;
            5: return 4'b1110;
            6: return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic int code_idx(input logic [3:0] c);
        for (int k = 0; k < 8; k++) begin
            if (canon(k) == c) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Behavioural model state
    int         m_mode   = M_IDLE;
    int         m_run    = 0;
    int         m_idx    = 0;
    int         m_revcnt = 0;
    int         m_errcnt = 0;
    logic       m_valid  = 1'b0;
    logic       m_seqerr = 1'b0;
    logic       m_rev    = 1'b0;
    logic [7:0] m_onehot = 8'h00;
    logic [3:0] m_last   = 4'b0000;
    logic [3:0] s_code;
    logic       s_rst;

    task model_step(input logic [3:0] c, input logic r);
        int  i;
        int  li;
        bit  legal;
        bit  succ;
        if (r) begin
            m_mode = M_IDLE; m_run = 0; m_idx = 0; m_revcnt = 0; m_errcnt = 0;
            m_valid = 1'b0; m_seqerr = 1'b0; m_rev = 1'b0; m_onehot = 8'h00;
            m_last = 4'b0000;
            return;
        end
        i     = code_idx(c);
        li    = code_idx(m_last);
        legal = (i >= 0);
        succ  = legal && (li >= 0) && (i == (li + 1) % 8);
        m_seqerr = 1'b0;
        m_rev    = 1'b0;
        case (m_mode)
            M_IDLE: if (legal) begin m_mode = M_ACQ; m_run = 0; end
            M_ACQ: begin
                if (!legal) m_mode = M_IDLE;
                else if (!succ) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_mode = M_LOCK;
                end
            end
            M_LOCK: begin
                if (succ) begin
                    if (i == 0) begin
                        m_rev    = 1'b1;
                        m_revcnt = (m_revcnt + 1) % (1 << REV_W);
                    end
                end else begin
                    m_mode   = M_FAULT;
                    m_seqerr = 1'b1;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
            default: begin m_mode = legal ? M_ACQ : M_IDLE; m_run = 0; end
        endcase
        m_valid = legal;
        if (legal) begin
            m_idx    = i;
            m_onehot = 8'h01 << i;
        end else begin
            m_onehot = 8'h00;
        end
        m_last = c;
    endtask

    // Per-cycle compare of every output against the model.
    always begin
        @(posedge clk);
        s_code = count_in;
        s_rst  = reset;
        #1;
        model_step(s_code, s_rst);
        chk("phase_idx",    32'(phase_idx),    32'(m_idx));
        chk("phase_onehot", 32'(phase_onehot), 32'(m_onehot));
        chk("code_valid",   32'(code_valid),   32'(m_valid));
        chk("locked",       32'(locked),       32'(m_mode == M_LOCK));
        chk("fault",        32'(fault),        32'(m_mode == M_FAULT));
        chk("seq_err",      32'(seq_err),      32'(m_seqerr));
        chk("rev_pulse",    32'(rev_pulse),    32'(m_rev));
        chk("rev_count",    32'(rev_count),    32'(m_revcnt));
        chk("err_count",    32'(err_count),    32'(m_errcnt));
    end

    task automatic step(input logic [3:0] c);
        count_in = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        count_in = 4'b0000;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    int         p;
    int         k;
    int unsigned roll;
    logic [3:0] nxt;

    initial begin
        reset    = 1'b1;
        count_in = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_locked",    32'(locked),       32'd0);
        chk("rst_onehot",    32'(phase_onehot), 32'd0);
        chk("rst_rev_count", 32'(rev_count),    32'd0);
        chk("rst_err_count", 32'(err_count),    32'd0);

        // Canonical sequence to lock and revolutions
        for (int j = 0; j <= 8; j++) begin
            step(canon(j));
            chk("seq_phase_idx", 32'(phase_idx), 32'(j % 8));
            if (j == 3) chk("not_yet_locked", 32'(locked), 32'd0);
            if (j == 4) chk("locked_at_1111", 32'(locked), 32'd1);
            if (j == 6) chk("onehot_1100",    32'(phase_onehot), 32'h40);
        end
        chk("rev_pulse_first", 32'(rev_pulse), 32'd1);
        chk("rev_count_one",   32'(rev_count), 32'd1);
        step(canon(1));
        chk("rev_pulse_drop",  32'(rev_pulse), 32'd0);
        for (int j = 2; j <= 16; j++) step(canon(j));
        chk("rev_count_three", 32'(rev_count), 32'd3);
        chk("model_revcnt",    32'(m_revcnt),  32'd3);

        // Illegal code while locked at 0011
        step(canon(1));
        step(canon(2));
        step(4'b0101);
        chk("ill_code_valid", 32'(code_valid),   32'd0);
        chk("ill_onehot",     32'(phase_onehot), 32'd0);
        chk("ill_idx_hold",   32'(phase_idx),    32'd2);
        chk("ill_seq_err",    32'(seq_err),      32'd1);
        chk("ill_fault",      32'(fault),        32'd1);
        chk("ill_err_count",  32'(err_count),    32'd1);
        step(4'b0000);
        chk("reacq_locked",   32'(locked), 32'd0);
        chk("reacq_fault",    32'(fault),  32'd0);
        chk("model_acq",      32'(m_mode), 32'(M_ACQ));

        // Relock, then stall at 0111
        for (int j = 1; j <= 11; j++) step(canon(j));
        chk("relock", 32'(locked), 32'd1);
        step(4'b0111);
        chk("stall_seq_err",   32'(seq_err),   32'd1);
        chk("stall_fault",     32'(fault),     32'd1);
        chk("stall_err_count", 32'(err_count), 32'd2);
        for (int j = 4; j <= 7; j++) step(canon(j));
        chk("stall_acq", 32'(locked), 32'd0);
        step(canon(8));
        chk("lock_on_zero",        32'(locked),    32'd1);
        chk("no_rev_on_lock_entry", 32'(rev_pulse), 32'd0);
        chk("rev_count_four",      32'(rev_count), 32'd4);

        // Reset mid-lock
        step(canon(1));
        reset = 1'b1;
        step(canon(2));
        reset = 1'b0;
        chk("midrst_locked",    32'(locked),    32'd0);
        chk("midrst_rev_count", 32'(rev_count), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        for (int j = 3; j <= 6; j++) step(canon(j));
        chk("postrst_unlocked", 32'(locked), 32'd0);
        step(canon(7));
        chk("postrst_locked",   32'(locked),    32'd1);
        chk("postrst_idx",      32'(phase_idx), 32'd7);

        // rev_count wrap after 257 revolutions
        do_reset();
        for (int j = 0; j <= 8 * 257; j++) step(canon(j));
        chk("rev_wrap", 32'(rev_count), 32'd1);

        // err_count saturation over 256 loss-of-lock events
        p = 0;
        for (int e = 0; e < 256; e++) begin
            step(canon(p));
            chk("sat_seq_err",   32'(seq_err),   32'd1);
            chk("sat_err_count", 32'(err_count), 32'((e + 1 > 255) ? 255 : e + 1));
            for (int j = 1; j <= 5; j++) step(canon(p + j));
            p = p + 5;
            chk("sat_relock", 32'(locked), 32'd1);
        end
        chk("err_saturated", 32'(err_count), 32'd255);

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            roll = $urandom_range(99);
            k    = code_idx(count_in);
            if (k < 0) k = 0;
            if (roll < 3) begin
                reset = 1'b1;
                nxt   = 4'($urandom);
            end else if (roll < 78) begin
                nxt = canon(k + 1);
            end else if (roll < 84) begin
                nxt = count_in;
            end else if (roll < 89) begin
                nxt = canon(k + 2);
            end else if (roll < 94) begin
                nxt = canon(int'($urandom_range(7)));
            end else begin
                nxt = 4'($urandom);
            end
            step(nxt);
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
